// File: rtl/tpumac_pkg.sv
// Shared widths, sum-width helper and saturation helper for the tpumac_pipe MAC cell.
package tpumac_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned BITS_C_DEF  = 16;
  localparam int unsigned LANES_DEF   = 1;
  localparam int unsigned SAT_W       = 64;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] val;
  } sat_t;

  // Exact width of a LANES-wide sum of BITS_AB x BITS_AB signed products.
  function automatic int unsigned sumw(input int unsigned bits_ab, input int unsigned lanes);
    return 2 * bits_ab + $clog2(lanes);
  endfunction

  // Clamp a signed value into the signed range of w bits; ovf flags a clamp.
  function automatic sat_t saturate(input logic signed [SAT_W-1:0] v, input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t                    r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/tpumac_dot.sv
// Combinational LANES-wide signed multiply-and-sum, exact to SUMW bits.
module tpumac_dot
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned SUMW    = sumw(BITS_AB_DEF, LANES_DEF)
) (
  input  logic [LANES*BITS_AB-1:0] a_i,
  input  logic [LANES*BITS_AB-1:0] b_i,
  output logic signed [SUMW-1:0]   dot_o
);

  localparam int unsigned PW = 2 * BITS_AB;

  always_comb begin
    logic signed [BITS_AB-1:0] sa;
    logic signed [BITS_AB-1:0] sb;
    logic signed [PW-1:0]      prod;
    dot_o = '0;
    sa    = '0;
    sb    = '0;
    prod  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sa    = a_i[i*BITS_AB +: BITS_AB];
      sb    = b_i[i*BITS_AB +: BITS_AB];
      prod  = PW'(sa) * PW'(sb);
      dot_o = dot_o + SUMW'(prod);
    end
  end

endmodule

// File: rtl/tpumac_pipe.sv
// Systolic MAC cell: operand forwarding, one-stage product pipeline, loadable accumulator.
// Define TPUMAC_SAT_EN for saturating accumulation with a sticky ovf flag; default wraps.
module tpumac_pipe
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEF,
  parameter int unsigned BITS_C  = BITS_C_DEF,
  parameter int unsigned LANES   = LANES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     WrEn,
  input  logic [LANES*BITS_AB-1:0] Ain,
  input  logic [LANES*BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]        Cin,
  output logic [LANES*BITS_AB-1:0] Aout,
  output logic [LANES*BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]        Cout,
  output logic                     ovf
);

  localparam int unsigned SUMW = sumw(BITS_AB, LANES);
  localparam int unsigned AW   = ((BITS_C > SUMW) ? BITS_C : SUMW) + 1;

  logic [LANES*BITS_AB-1:0] a_q, a_d, b_q, b_d;
  logic signed [SUMW-1:0]   p1_q, p1_d;
  logic                     vld_q, vld_d;
  logic signed [BITS_C-1:0] c_q, c_d;
  logic signed [SUMW-1:0]   dot;
  logic signed [AW-1:0]     acc_sum;
  logic signed [BITS_C-1:0] acc_next;
  logic                     acc_ovf;

  tpumac_dot #(.BITS_AB(BITS_AB), .LANES(LANES), .SUMW(SUMW)) u_dot (
    .a_i   (Ain),
    .b_i   (Bin),
    .dot_o (dot)
  );

  assign acc_sum = AW'(c_q) + AW'(p1_q);

`ifdef TPUMAC_SAT_EN
  sat_t sat;
  logic ovf_q, ovf_d;

  assign sat      = saturate(SAT_W'(acc_sum), BITS_C);
  assign acc_next = sat.val[BITS_C-1:0];
  assign acc_ovf  = sat.ovf;

  // Sticky: only clr or reset drop it; a load leaves it set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (!WrEn && en && vld_q && acc_ovf) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign acc_next = acc_sum[BITS_C-1:0];
  assign acc_ovf  = 1'b0;
  assign ovf      = 1'b0;
`endif

  // Priority clr > WrEn > accumulate; loads and clears ignore en.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p1_d  = p1_q;
    vld_d = vld_q;
    c_d   = c_q;
    if (en) begin
      a_d = Ain;
      b_d = Bin;
    end
    if (clr) begin
      c_d   = '0;
      vld_d = 1'b0;
    end else if (WrEn) begin
      c_d = Cin;
      if (en) begin
        p1_d  = dot;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end else if (en) begin
      if (vld_q) c_d = acc_next;
      p1_d  = dot;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      p1_q  <= '0;
      vld_q <= 1'b0;
      c_q   <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p1_q  <= p1_d;
      vld_q <= vld_d;
      c_q   <= c_d;
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = c_q;

endmodule

// File: tb/tb_tpumac_pipe.sv
// Scoreboard bench for tpumac_pipe: a 4-lane and a 1-lane instance share control inputs.
module tb_tpumac_pipe;

  typedef logic [113:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, wr;
  logic [31:0] ain, bin;
  logic [15:0] cin;
  logic [31:0] aout4, bout4;
  logic [15:0] cout4, cout1;
  logic [7:0]  aout1, bout1;
  logic        ovf4, ovf1;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];

  int   mc4, mc1, mp4, mp1;
  logic mv, mo4, mo1;
  logic [31:0] ma, mb;

  always #5 clk = ~clk;

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .WrEn(wr),
    .Ain(ain), .Bin(bin), .Cin(cin),
    .Aout(aout4), .Bout(bout4), .Cout(cout4), .ovf(ovf4)
  );

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .WrEn(wr),
    .Ain(ain[7:0]), .Bin(bin[7:0]), .Cin(cin),
    .Aout(aout1), .Bout(bout1), .Cout(cout1), .ovf(ovf1)
  );

  function automatic vec_t obs();
    return {cout4, cout1, ovf4, ovf1, aout4, bout4, aout1, bout1};
  endfunction

  function automatic int reduce(input int s, inout logic o);
`ifdef TPUMAC_SAT_EN
    if (s > 32767) begin o = 1'b1; return 32767; end
    if (s < -32768) begin o = 1'b1; return -32768; end
    return s;
`else
    logic signed [15:0] t;
    t = 16'(s);
    return int'(t);
`endif
  endfunction

  task automatic model_reset();
    mc4 = 0; mc1 = 0; mp4 = 0; mp1 = 0;
    mv = 1'b0; mo4 = 1'b0; mo1 = 1'b0;
    ma = '0; mb = '0;
  endtask

  // Drive one cycle, advance the model, queue the expected post-edge outputs.
  task automatic step(input logic e, input logic c, input logic w, input int ci,
                      input logic [31:0] a, input logic [31:0] b);
    int d4, d1;
    en = e; clr = c; wr = w; cin = 16'(ci); ain = a; bin = b;
    d4 = 0;
    for (int i = 0; i < 4; i++)
      d4 += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
    d1 = int'($signed(a[7:0])) * int'($signed(b[7:0]));
    if (e) begin ma = a; mb = b; end
    if (c) begin
      mc4 = 0; mc1 = 0; mv = 1'b0; mo4 = 1'b0; mo1 = 1'b0;
    end else if (w) begin
      mc4 = ci; mc1 = ci;
      if (e) begin mp4 = d4; mp1 = d1; mv = 1'b1; end
      else mv = 1'b0;
    end else if (e) begin
      if (mv) begin
        mc4 = reduce(mc4 + mp4, mo4);
        mc1 = reduce(mc1 + mp1, mo1);
      end
      mp4 = d4; mp1 = d1; mv = 1'b1;
    end
    sb.push_back({16'(mc4), 16'(mc1), mo4, mo1, ma, mb, ma[7:0], mb[7:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; wr = 1'b0; cin = '0; ain = '0; bin = '0;
    model_reset();
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs(), vec_t'(0));
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), vec_t'(0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lanes1();
    vec_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 32'h0000_0003, 32'h0000_00FC);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL lanes1_step%0d got=%h exp=%h", i, obs(), e);
      end
    end
    checks++;
    if ({aout1, cout1} !== {8'h03, 16'hFFE8}) begin
      failures++;
      $display("FAIL lanes1_final got=%h/%h exp=03/ffe8", aout1, cout1);
    end
  endtask

  task automatic test_dot4();
    vec_t e;
    logic [31:0] av [4] = '{32'h0, 32'h0403_0201, 32'h0, 32'h0};
    logic [31:0] bv [4] = '{32'h0, 32'h0807_0605, 32'h0, 32'h0};
    logic        cv [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(~cv[i], cv[i], 1'b0, 0, av[i], bv[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL dot4_step%0d got=%h exp=%h", i, obs(), e);
      end
      if (i == 2) begin
        checks++;
        if ({cout4, cout1} !== {16'd70, 16'd5}) begin
          failures++;
          $display("FAIL dot4_value got=%0d/%0d exp=70/5", cout4, cout1);
        end
      end
    end
  endtask

  task automatic test_load();
    vec_t e;
    int          ci [5] = '{100, 0, -7, 0, 0};
    logic        wv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] av [5] = '{32'h0, 32'h05, 32'h02, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      step(ev[i], 1'b0, wv[i], ci[i], av[i], av[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL load_step%0d got=%h exp=%h", i, obs(), e);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (cout4 !== ((i == 2) ? 16'hFFF9 : 16'hFFFD)) begin
          failures++;
          $display("FAIL load_value%0d got=%h exp=%h", i, cout4,
                   ((i == 2) ? 16'hFFF9 : 16'hFFFD));
        end
      end
    end
  endtask

  task automatic test_overflow();
    vec_t e;
    logic [16:0] lit;
    int          ci [6] = '{0, 32760, 0, 0, -32760, 0};
    logic        wv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        cv [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] av [6] = '{32'h0, 32'h7F, 32'h0, 32'h0, 32'h7F, 32'h0};
    logic [31:0] bv [6] = '{32'h0, 32'h7F, 32'h0, 32'h0, 32'h80, 32'h0};
`ifdef TPUMAC_SAT_EN
    lit = {16'h7FFF, 1'b1};
`else
    lit = {16'hBEF9, 1'b0};
`endif
    for (int i = 0; i < 6; i++) begin
      step(~cv[i], cv[i], wv[i], ci[i], av[i], bv[i]);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL ovf_step%0d got=%h exp=%h", i, obs(), e);
      end
      if (i == 2) begin
        checks++;
        if ({cout1, ovf1} !== lit) begin
          failures++;
          $display("FAIL ovf_value got=%h exp=%h", {cout1, ovf1}, lit);
        end
      end
    end
  endtask

  task automatic test_stall();
    vec_t e;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) step(1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0);
      else if (i < 3) step(1'b1, 1'b0, 1'b0, 0, 32'h0303_0303 + 32'(i), 32'h0201_FF05);
      else if (i < 8) step(1'b0, 1'b0, 1'b0, 0, $urandom, $urandom);
      else step(1'b1, 1'b0, 1'b0, 0, 32'h0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL stall_step%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  task automatic test_clr_wr();
    vec_t e;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 2), (i == 2), 55, 32'h1122_3344, 32'h0506_0708);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL clrwr_step%0d got=%h exp=%h", i, obs(), e);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== '0) begin
      failures++;
      $display("FAIL midreset got=%h exp=%h", obs(), vec_t'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 32'h0000_0009, 32'h0000_0007);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL restart_step%0d got=%h exp=%h", i, obs(), e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lanes1();
    test_dot4();
    test_load();
    test_overflow();
    test_stall();
    test_clr_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpumac_pipe.md
# tpumac_pipe

Second-generation systolic MAC cell for the TPU array. It takes LANES signed A/B operand pairs per cycle and forwards them to the neighbouring cells. The dot product is held in a one-stage product pipeline, then accumulated into a BITS_C-bit signed accumulator that can be loaded, cleared or drained. Overflow handling, wrapping or saturating, is chosen at compile time.

## Interface
Parameters:
- BITS_AB, 8, signed width of each A/B operand.
- BITS_C, 16, signed accumulator width; must be at least 2*BITS_AB.
- LANES, 1, operand pairs per cycle; must be a power of two, 1 to 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- en  in  1  advance enable for operand forwarding and the pipeline
- clr  in  1  synchronous clear of the accumulator, pipeline and flag
- WrEn  in  1  load Cin into the accumulator
- Ain  in  LANES*BITS_AB  packed signed operands; lane i is [i*BITS_AB +: BITS_AB]
- Bin  in  LANES*BITS_AB  packed signed operands, same packing as Ain
- Cin  in  BITS_C  signed load value
- Aout  out  LANES*BITS_AB  registered copy of Ain
- Bout  out  LANES*BITS_AB  registered copy of Bin
- Cout  out  BITS_C  signed accumulator
- ovf  out  1  sticky saturation flag

## Operation
- Reset: Aout, Bout, Cout, ovf, the internal product register p1 and its valid bit p1_vld all go to 0.
- Operand forwarding: at a clock edge with en=1, Aout<=Ain and Bout<=Bin. Otherwise Aout and Bout hold. clr and WrEn do not affect Aout or Bout.
- Dot product: the sum over all lanes of Ain[i]*Bin[i].
  - Each product is 2*BITS_AB bits wide, exact.
  - The sum is SUMW = 2*BITS_AB + log2(LANES) bits wide, exact.
- Pipeline stage: at an edge with en=1, p1<=dot and p1_vld<=1.
- Accumulate: at an edge with en=1 and p1_vld=1, Cout<=Cout+p1.
  - The addition is done in max(BITS_C,SUMW)+1 bits, then reduced to BITS_C bits as set under Configuration.
  - With en=0, p1, p1_vld and Cout hold.
- Priority at an edge is clr > WrEn > accumulate.
  - clr: Cout<=0, p1_vld<=0, ovf<=0. A product presented in the same cycle with en=1 is discarded.
  - WrEn: Cout<=Cin, and the p1 already in flight is discarded. If en=1 in the same cycle, p1 and p1_vld load the new product; otherwise p1_vld<=0.
- WrEn takes effect without en, matching the first-generation load behaviour.

## Timing
- Latency from Ain/Bin to Aout/Bout: 1 cycle.
- Latency from Ain/Bin to a contribution in Cout: 2 en-cycles.
- Latency from WrEn or clr to Cout: 1 cycle.
- Reset asserted in mid-operation clears everything immediately, including the in-flight product. The first edge after release behaves as a fresh start: p1_vld=0, so there is no accumulate on that edge.
- There is no backpressure. en stalls all sequential state except loads and clears.

## Configuration
- TPUMAC_SAT_EN defined:
  - A sum outside the signed BITS_C range clamps to 2^(BITS_C-1)-1 or -2^(BITS_C-1).
  - ovf is set and stays set until clr or reset.
  - WrEn does not clear ovf.
- TPUMAC_SAT_EN undefined:
  - The sum is truncated to its low BITS_C bits, i.e. two's-complement wrap.
  - ovf is tied to 0.

## Structure
- Package tpumac_pkg holds:
  - the localparam function computing SUMW;
  - a saturate function (value, width) returning the clamped value plus an overflow bit;
  - the packed lane-slice macro widths.
- Sub-module tpumac_dot: purely combinational LANES-wide signed multiply-and-sum, output width SUMW.
- The top level holds the forwarding registers, p1/p1_vld, the accumulator, ovf and the priority logic.

## Test plan
1. Reset, then LANES=1, en=1, A=3, B=-4 for 3 cycles -> Cout sequence 0, -12, -24. Aout=3 one cycle after the first edge.
2. LANES=4, lanes A={1,2,3,4}, B={5,6,7,8}, one en pulse followed by en=1 with A=B=0 -> Cout=70 after 2 edges.
3. Cout=100, then WrEn=1, Cin=-7 with en=1 and A=2, B=2 -> Cout=-7 next cycle, then -3 the cycle after. The in-flight product from before WrEn must not appear.
4. With the macro defined, WrEn Cin=32760, then A=B=127 -> Cout=32767, ovf=1. Without the macro -> Cout=-16647, ovf=0.
5. en=0 for 5 cycles while in flight -> Aout, Bout and Cout frozen; accumulation resumes at the next en=1.
6. clr and WrEn in the same cycle -> Cout=0, ovf=0. Reset asserted mid-accumulation -> all outputs 0 asynchronously.
